// File: rtl/tone_pkg.sv
// Shared tone-path definitions: measurement state encoding and the default
// half-period width / silence timeout used by generator, sequencer and meter.
package tone_pkg;

    localparam int                      TONE_WIDTH   = 22;
    localparam logic [TONE_WIDTH-1:0]   TONE_TIMEOUT = 22'h3FFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } tone_state_t;

endpackage

// File: rtl/edge_sync.sv
// Three-flop synchroniser for an asynchronous level, with a one-cycle pulse
// on every transition (rising or falling) of the synchronised signal.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_edge
);

    logic r_s1, r_s2, r_s3;

    // s1/s2 resolve metastability; s3 is the delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_edge = r_s2 ^ r_s3;

endmodule

// File: rtl/tone_meter.sv
// Square-wave meter: measures the spacing between input edges and reports it
// in the generator's encoding (spacing N clk -> value N-1), flags stability
// (locked) and absence of edges (silent).
module tone_meter
    import tone_pkg::*;
#(
    parameter int               WIDTH      = TONE_WIDTH,
    parameter logic [WIDTH-1:0] TIMEOUT    = WIDTH'(TONE_TIMEOUT),
    parameter int               LOCK_COUNT = 3,
    parameter int               TOL        = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sound_in,
    output logic [WIDTH-1:0] half_period,
    output logic             valid,
    output logic             locked,
    output logic             silent
);

    localparam logic [3:0]       LOCK_N = 4'(LOCK_COUNT);
    localparam logic [WIDTH-1:0] TOL_W  = WIDTH'(TOL);

    tone_state_t      r_state, w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_prev_meas;
    logic [WIDTH-1:0] r_half_period;
    logic             r_valid;
    logic [3:0]       r_match_cnt;
    logic [3:0]       w_match_next;
    logic [3:0]       w_match_inc;
    logic [WIDTH-1:0] w_diff;
    logic             w_edge;
    logic             w_timeout;
    logic             w_meas;
    logic             w_match;
    logic             w_to_idle;
    logic             w_discard;

    edge_sync u_edge_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (sound_in),
        .o_edge  (w_edge)
    );

    assign w_timeout = (r_count == TIMEOUT);
    // An edge landing on a saturated count ends an interval of unknown length:
    // it is not measured, but it does start the next interval.
    assign w_to_idle = (r_state != IDLE) && w_timeout && !w_edge;
    assign w_discard = (r_state != IDLE) && w_timeout &&  w_edge;
    assign w_meas    = (r_state != IDLE) && !w_timeout && w_edge;

    // Unsigned distance, larger minus smaller so it never wraps
    assign w_diff      = (r_count >= r_prev_meas) ? (r_count - r_prev_meas)
                                                  : (r_prev_meas - r_count);
    assign w_match     = (w_diff <= TOL_W);
    assign w_match_inc = (r_match_cnt >= LOCK_N) ? LOCK_N : (r_match_cnt + 4'd1);

    // Consecutive-match counter update; mismatch restarts the run at one
    always_comb begin
        w_match_next = r_match_cnt;
        if (w_to_idle || w_discard)
            w_match_next = 4'd0;
        else if (w_meas)
            w_match_next = w_match ? w_match_inc : 4'd1;
    end

    // Edge-interval counter: cleared on every edge, saturates at TIMEOUT
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_count <= '0;
        else if (w_edge)
            r_count <= '0;
        else if (!w_timeout)
            r_count <= r_count + WIDTH'(1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state: lock after LOCK_COUNT matching runs, drop on mismatch or silence
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_edge)
                    w_state_next = ARMED;
            end
            ARMED: begin
                if (w_to_idle)
                    w_state_next = IDLE;
                else if (w_discard)
                    w_state_next = ARMED;
                else if (w_meas && (w_match_next == LOCK_N))
                    w_state_next = LOCKED;
            end
            LOCKED: begin
                if (w_to_idle)
                    w_state_next = IDLE;
                else if (w_discard)
                    w_state_next = ARMED;
                else if (w_meas && !w_match)
                    w_state_next = ARMED;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Match bookkeeping; the reference measurement is cleared whenever we go idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_match_cnt <= '0;
            r_prev_meas <= '0;
        end else begin
            r_match_cnt <= w_match_next;
            if (w_to_idle)
                r_prev_meas <= '0;
            else if (w_meas)
                r_prev_meas <= r_count;
        end
    end

    // Published measurement and its one-cycle update strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_half_period <= '0;
            r_valid       <= 1'b0;
        end else begin
            r_valid <= w_meas;
            if (w_meas)
                r_half_period <= r_count;
        end
    end

    // Outputs: locked/silent follow the registered state directly
    always_comb begin
        half_period = r_half_period;
        valid       = r_valid;
        locked      = (r_state == LOCKED);
        silent      = (r_state == IDLE);
    end

endmodule
